// File: rtl/output_port_scheduler_pkg.sv
// Shared flit type codes, FSM state encodings and small decode helpers
// for the output port scheduler.
package output_port_scheduler_pkg;

    typedef enum logic [2:0] {
        FLIT_HEADER   = 3'd1,
        FLIT_BODY     = 3'd2,
        FLIT_TAIL     = 3'd3,
        FLIT_HEADTAIL = 3'd4
    } flit_type_e;

    // One-hot: bit0 = IDLE, bit1 = GRANT_L, bit2 = GRANT_N, bit3 = GRANT_E.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_GRANT_L = 4'b0010,
        ST_GRANT_N = 4'b0100,
        ST_GRANT_E = 4'b1000
    } sched_state_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_L    = 2'd1;
    localparam logic [1:0] SEL_N    = 2'd2;
    localparam logic [1:0] SEL_E    = 2'd3;

    // Per-input one-hot vectors: bit0 = L, bit1 = N, bit2 = E.
    localparam logic [2:0] PORT_L = 3'b001;

    function automatic logic is_head_flit(input logic [2:0] t);
        return (t == FLIT_HEADER) || (t == FLIT_HEADTAIL);
    endfunction

    function automatic logic is_tail_flit(input logic [2:0] t);
        return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
    endfunction

    function automatic sched_state_e grant_state(input logic [2:0] winner);
        case (winner)
            3'b001:  return ST_GRANT_L;
            3'b010:  return ST_GRANT_N;
            3'b100:  return ST_GRANT_E;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/output_port_scheduler_if.sv
// Handshake bundle between the three input queues / crossbar (master side)
// and the output port scheduler (slave side).
interface output_port_scheduler_if;
    logic [2:0] req;
    logic [2:0] Lflit_type;
    logic [2:0] Nflit_type;
    logic [2:0] Eflit_type;
    logic       credit_in;
    logic [2:0] pop;
    logic [1:0] sel;
    logic       valid_out;
    logic [3:0] state;
    logic       cred_err;

    modport master (
        output req, Lflit_type, Nflit_type, Eflit_type, credit_in,
        input  pop, sel, valid_out, state, cred_err
    );

    modport slave (
        input  req, Lflit_type, Nflit_type, Eflit_type, credit_in,
        output pop, sel, valid_out, state, cred_err
    );
endinterface

// File: rtl/output_port_scheduler_rr_pick3.sv
// Stateless three-way round-robin picker. The search starts at the input
// following last_served (L -> N -> E -> L), so last_served itself has the
// lowest priority.
module rr_pick3 (
    input  logic [2:0] eligible,
    input  logic [2:0] last_served,
    output logic [2:0] winner
);

    // Priority chain rotated by last_served; winner is one-hot or zero.
    always_comb begin
        winner = 3'b000;
        case (last_served)
            3'b100: begin
                if      (eligible[0]) winner = 3'b001;
                else if (eligible[1]) winner = 3'b010;
                else if (eligible[2]) winner = 3'b100;
            end
            3'b010: begin
                if      (eligible[2]) winner = 3'b100;
                else if (eligible[0]) winner = 3'b001;
                else if (eligible[1]) winner = 3'b010;
            end
            default: begin
                if      (eligible[1]) winner = 3'b010;
                else if (eligible[2]) winner = 3'b100;
                else if (eligible[0]) winner = 3'b001;
            end
        endcase
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Output port scheduler: wormhole grant FSM over inputs L/N/E with a
// downstream credit counter. Optional grant watchdog is compiled in with
// the SCHED_WATCHDOG_EN macro (adds the timeout output port).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no grant; arbitrate among inputs presenting a head flit
// ST_GRANT_L | packet from L owns the output until its tail is popped
// ST_GRANT_N | packet from N owns the output until its tail is popped
// ST_GRANT_E | packet from E owns the output until its tail is popped
module output_port_scheduler
    import output_port_scheduler_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    output_port_scheduler_if.slave bus
`ifdef SCHED_WATCHDOG_EN
    ,
    output logic timeout
`endif
);

    if (CREDITS < 1 || CREDITS > 15) begin : g_credits_range
        $error("output_port_scheduler: CREDITS must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 4095) begin : g_timeout_range
        $error("output_port_scheduler: TIMEOUT must be 1..4095");
    end

    sched_state_e state_q, state_d;
    logic [3:0]   credit_cnt;
    logic [2:0]   last_served_q;
    logic         cred_err_q;

    logic [2:0] grant_vec, eligible, pick_elig, pick_last, winner;
    logic [2:0] pop, granted_type;
    logic [1:0] sel;
    logic       credits_nz, pop_any, release_grant, wd_fire;

    assign grant_vec = state_q[3:1];
    assign eligible  = bus.req & {is_head_flit(bus.Eflit_type),
                                  is_head_flit(bus.Nflit_type),
                                  is_head_flit(bus.Lflit_type)};
    // On release the granted input is masked and treated as last served,
    // so it can never be handed straight back its own grant.
    assign pick_elig = eligible & ~grant_vec;
    assign pick_last = (state_q == ST_IDLE) ? last_served_q : grant_vec;

    rr_pick3 u_rr_pick3 (
        .eligible    (pick_elig),
        .last_served (pick_last),
        .winner      (winner)
    );

    assign credits_nz    = (credit_cnt != 4'd0);
    assign pop_any       = |pop;
    assign release_grant = (pop_any && is_tail_flit(granted_type)) || wd_fire;

    // Head flit type of whichever input currently holds the grant.
    always_comb begin
        case (grant_vec)
            3'b001:  granted_type = bus.Lflit_type;
            3'b010:  granted_type = bus.Nflit_type;
            3'b100:  granted_type = bus.Eflit_type;
            default: granted_type = FLIT_BODY;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: arbitrate from IDLE or on release, otherwise hold (stalls included).
    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE || release_grant) begin
            state_d = grant_state(winner);
        end
    end

    // Outputs: pop only with data and credit; sel follows the grant even when stalled.
    always_comb begin
        pop = 3'b000;
        sel = SEL_NONE;
        if (!rst) begin
            pop = grant_vec & bus.req & {3{credits_nz}};
            case (state_q)
                ST_GRANT_L: sel = SEL_L;
                ST_GRANT_N: sel = SEL_N;
                ST_GRANT_E: sel = SEL_E;
                default:    sel = SEL_NONE;
            endcase
        end
    end

    assign bus.pop       = pop;
    assign bus.sel       = sel;
    assign bus.valid_out = pop_any;
    assign bus.state     = state_q;
    assign bus.cred_err  = cred_err_q;

    // Credit counter; an overflowing credit is dropped and flagged stickily.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= 4'(CREDITS);
            cred_err_q <= 1'b0;
        end else if (pop_any && !bus.credit_in) begin
            credit_cnt <= credit_cnt - 4'd1;
        end else if (!pop_any && bus.credit_in) begin
            if (credit_cnt == 4'(CREDITS)) cred_err_q <= 1'b1;
            else                           credit_cnt <= credit_cnt + 4'd1;
        end
    end

    // Round-robin pointer moves only when a grant is released.
    always_ff @(posedge clk) begin
        if (rst)                last_served_q <= PORT_L;
        else if (release_grant) last_served_q <= grant_vec;
    end

`ifdef SCHED_WATCHDOG_EN
    logic [11:0] wd_cnt;

    assign wd_fire = !rst && (state_q != ST_IDLE) && !pop_any && (wd_cnt == 12'(TIMEOUT));
    assign timeout = wd_fire;

    // Idle-grant cycle counter; any pop or state change restarts it.
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_IDLE || pop_any || state_d != state_q) wd_cnt <= 12'd0;
        else                                                             wd_cnt <= wd_cnt + 12'd1;
    end
`else
    assign wd_fire = 1'b0;
`endif

endmodule

// File: doc/output_port_scheduler.md
OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

Interface
REQ-001 Parameter CREDITS, default 4: downstream input-buffer depth in flits (range 1..15).
REQ-002 Parameter TIMEOUT, default 255: watchdog limit in cycles, used only when the watchdog is compiled in (range 1..4095).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  3  per-input "flit available" flags, bit0=L, bit1=N, bit2=E.
REQ-006 Lflit_type, Nflit_type, Eflit_type  input  3 each  type of the head flit of each input queue.
REQ-007 credit_in  input  1  one-cycle pulse; the downstream buffer freed one slot.
REQ-008 pop  output  3  one-hot dequeue strobe to the granted input queue.
REQ-009 sel  output  2  crossbar select: 0=none, 1=L, 2=N, 3=E.
REQ-010 valid_out  output  1  a flit crosses to the output this cycle.
REQ-011 state  output  4  one-hot state, bit0=IDLE, bits[3:1]=GRANT_E/N/L.
REQ-012 cred_err  output  1  sticky flag; a credit was received while the counter was already full.

Function
REQ-013 The scheduler shall be a one-hot FSM with states IDLE, GRANT_L, GRANT_N and GRANT_E, and a 4-bit credit counter.
REQ-014 In IDLE, an input is eligible only if req=1 and its flit_type is HEADER or HEADTAIL; the winner shall be chosen round-robin, starting after last_served (reset value L, so the order is N, E, L).
REQ-015 Arbitration shall have one cycle of latency: the winner's GRANT state is entered on the next edge, and no pop occurs in the arbitration cycle.
REQ-016 In GRANT_x, pop[x]=valid_out=1 exactly when req[x]=1 and credit count !=0 (combinational from registered state, req and count).
REQ-017 In GRANT_x, sel shall hold x's code in every cycle, whether or not a pop occurs; in IDLE, sel=0.
REQ-018 Each pop shall decrement the credit count and each credit_in shall increment it; a simultaneous pop and credit_in leaves the count unchanged.
REQ-019 A credit_in with the count at CREDITS, and no pop in the same cycle, shall leave the count at CREDITS and set cred_err.
REQ-020 Popping a flit of type TAIL or HEADTAIL shall end the grant and set last_served=x; the next state is the round-robin winner among the other inputs' eligible HEADER flits, else IDLE.
REQ-021 The same input shall not be re-granted directly on its own TAIL pop.
REQ-022 While in GRANT_x, a req[x] drop or zero credits shall stall (hold state, pop=0), never release the grant.
REQ-023 A HEADER arriving on a non-granted input shall not preempt the current packet.

Reset
REQ-024 On rst: state=IDLE, credit count=CREDITS, last_served=L, cred_err=0, watchdog counter=0.
REQ-025 While rst=1: pop=0, valid_out=0 and sel=0.
REQ-026 rst asserted mid-packet shall drop the grant with no further pops; the upstream is responsible for flushing.

Configuration
REQ-027 Macro SCHED_WATCHDOG_EN shall control the watchdog.
REQ-028 With SCHED_WATCHDOG_EN defined, a 12-bit counter shall count cycles spent in any GRANT state, clearing on every pop and on entering a state.
REQ-029 When the watchdog counter reaches TIMEOUT, the grant shall be released exactly as if a TAIL had been popped, and an output timeout pulse (1 bit) shall be asserted for one cycle.
REQ-030 Without SCHED_WATCHDOG_EN, neither the counter nor the timeout port shall exist, and grants are held indefinitely.

Structure
REQ-031 Flit type codes (HEADER, BODY, TAIL, HEADTAIL) and the state encodings (IDLE, GRANT_L/N/E) shall live in the shared parameters/defines package.
REQ-032 The round-robin pick shall be a sub-module rr_pick3 (inputs: 3-bit eligible vector and last_served; output: one-hot winner); it contains no state.
REQ-033 The credit counter and FSM shall remain in the top module.

Verification
REQ-034 Single packet on L (HEADER, 2×BODY, TAIL), CREDITS=4, no credit_in -> IDLE 1 cycle, then 4 pops on consecutive cycles, count=0, back to IDLE.
REQ-035 L and N both present HEADERs at reset -> N granted first; after N's TAIL, the state goes directly to GRANT_E or GRANT_L per round-robin order, with no IDLE cycle.
REQ-036 6-flit packet with CREDITS=2 and credit_in 3 cycles after each pop -> pop stalls at count=0, sel is held, 6 pops in total, no cred_err.
REQ-037 Simultaneous pop and credit_in at count=2 -> count stays 2; extra credit_in at count=4 with no pop -> count=4, cred_err=1.
REQ-038 rst asserted after the 2nd flit of a 5-flit packet -> next cycle state=IDLE, count=CREDITS, pop=0.
REQ-039 With SCHED_WATCHDOG_EN and TIMEOUT=8, req[L] dropped mid-packet -> timeout pulses after 8 cycles in GRANT_L, and the pending E HEADER is granted.
